// File: rtl/jtcop_sdram_pkg.sv
// Shared types and defaults for the SDRAM responder slice.
// FSM state enum, bank index type, default constants, one-hot helper.
package jtcop_sdram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_RD,
        ST_WR,
        ST_RFSH
    } state_t;

    typedef logic [1:0] bank_t;

    localparam int BURST_DEF       = 2;
    localparam int RFSH_PERIOD_DEF = 390;

    function automatic logic [3:0] bank_oh(input bank_t b);
        bank_oh = 4'b0001 << b;
    endfunction

endpackage

// File: rtl/jtcop_sdram_arb.sv
// Four-way bank arbiter; also holds the last-served bank (sel).
// Ports: req (bank requests), take (grant accepted), gnt_vld/gnt
// (combinational winner), sel (registered last-served bank).
// JTCOP_SDRAM_RR_EN: round-robin search starting after sel;
// otherwise fixed priority 0>1>2>3.
module jtcop_sdram_arb
    import jtcop_sdram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       take,
    output logic       gnt_vld,
    output bank_t      gnt,
    output bank_t      sel
);

    bank_t start;
    bank_t idx;
    logic  found;

    always_comb begin
`ifdef JTCOP_SDRAM_RR_EN
        start = sel + 2'd1;
`else
        start = 2'd0;
`endif
        gnt_vld = |req;
        gnt     = 2'd0;
        idx     = 2'd0;
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && req[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
    end

    // Reset to 3 so a round-robin search begins at bank 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= 2'd3;
        end else if (take) begin
            sel <= gnt;
        end
    end

endmodule

// File: rtl/jtcop_sdram_resp.sv
// SDRAM responder: arbitrates four bank requests, runs one burst
// read or bank-0 write at a time on a word-wide memory port, and
// schedules refresh between transactions.
// Ports: ba*_addr/ba_rd/ba_wr/ba0_din/ba0_din_m requests in;
// ba_ack/ba_dst/ba_dok/ba_rdy/data_read strobes out; mem_* port;
// rfsh/rfsh_ok refresh handshake.
// Macro JTCOP_SDRAM_RR_EN selects round-robin arbitration.
module jtcop_sdram_resp
    import jtcop_sdram_pkg::*;
#(
    parameter int AW          = 22,
    parameter int BURST       = BURST_DEF,
    parameter int RFSH_PERIOD = RFSH_PERIOD_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ba0_addr,
    input  logic [AW-1:0] ba1_addr,
    input  logic [AW-1:0] ba2_addr,
    input  logic [AW-1:0] ba3_addr,
    input  logic [3:0]    ba_rd,
    input  logic          ba_wr,
    input  logic [15:0]   ba0_din,
    input  logic [1:0]    ba0_din_m,
    output logic [3:0]    ba_ack,
    output logic [3:0]    ba_dst,
    output logic [3:0]    ba_dok,
    output logic [3:0]    ba_rdy,
    output logic [15:0]   data_read,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW+1:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic [1:0]    mem_mask,
    input  logic [15:0]   mem_dout,
    input  logic          mem_ok,
    output logic          rfsh,
    input  logic          rfsh_ok
);

    localparam logic [15:0] RFSH_LAST =
        (RFSH_PERIOD > 0) ? 16'(RFSH_PERIOD - 1) : 16'd0;

    state_t        state_q, state_d;
    logic          take;
    logic          gnt_vld;
    bank_t         gnt, sel;
    logic [AW-1:0] addr_mux;
    logic          wr_q;
    logic [1:0]    wcnt;
    logic          last;
    logic [15:0]   rfsh_cnt;
    logic          rfsh_pend;

    jtcop_sdram_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (ba_rd),
        .take    (take),
        .gnt_vld (gnt_vld),
        .gnt     (gnt),
        .sel     (sel)
    );

    always_comb begin
        addr_mux = ba0_addr;
        case (gnt)
            2'd1:    addr_mux = ba1_addr;
            2'd2:    addr_mux = ba2_addr;
            2'd3:    addr_mux = ba3_addr;
            default: ;
        endcase
    end

    assign last      = wcnt == 2'(BURST - 1);
    assign rfsh_pend = (RFSH_PERIOD > 0) && (rfsh_cnt == RFSH_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rfsh_pend) begin
                    state_d = ST_RFSH;
                end else if (gnt_vld) begin
                    take    = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = wr_q ? ST_WR : ST_RD;
            ST_RD:   if (mem_ok && last) state_d = ST_IDLE;
            ST_WR:   if (mem_ok) state_d = ST_IDLE;
            ST_RFSH: if (rfsh_ok) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ba_ack = (state_q == ST_ACK) ? bank_oh(sel) : 4'd0;
    assign rfsh   = state_q == ST_RFSH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ba_dst    <= '0;
            ba_dok    <= '0;
            ba_rdy    <= '0;
            data_read <= '0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_mask  <= '0;
            wr_q      <= 1'b0;
            wcnt      <= '0;
        end else begin
            ba_dst <= '0;
            ba_dok <= '0;
            ba_rdy <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        mem_addr <= {gnt, addr_mux};
                        mem_din  <= ba0_din;
                        mem_mask <= ba0_din_m;
                        wr_q     <= ba_wr && (gnt == 2'd0);
                        wcnt     <= '0;
                    end
                end
                ST_ACK: begin
                    mem_cs <= 1'b1;
                    mem_we <= wr_q;
                end
                ST_RD: begin
                    if (mem_ok) begin
                        data_read <= mem_dout;
                        ba_dok    <= bank_oh(sel);
                        wcnt      <= wcnt + 2'd1;
                        if (wcnt == 2'd0) ba_dst <= bank_oh(sel);
                        if (last) begin
                            ba_rdy <= bank_oh(sel);
                            mem_cs <= 1'b0;
                        end else begin
                            // Wrap inside the bank; never touch bank bits.
                            mem_addr[AW-1:0] <=
                                mem_addr[AW-1:0] + AW'(1);
                        end
                    end
                end
                ST_WR: begin
                    if (mem_ok) begin
                        ba_rdy <= bank_oh(sel);
                        mem_cs <= 1'b0;
                        mem_we <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Free-running; holds at the last count while a refresh waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rfsh_cnt <= '0;
        end else if (state_q == ST_RFSH && rfsh_ok) begin
            rfsh_cnt <= '0;
        end else if (!rfsh_pend) begin
            rfsh_cnt <= rfsh_cnt + 16'd1;
        end
    end

endmodule

// File: doc/jtcop_sdram_resp.md
Name: jtcop_sdram_resp

Overview:
- Responder end of the four-bank SDRAM request interface used by the game-side bank multiplexers (RAM/ROM slot banks 0-3).
- Accepts per-bank read requests and bank-0 writes, then arbitrates among them.
- Runs one transaction at a time on a generic word-wide memory port and returns ack/dst/dok/rdy strobes plus data_read to the requesting bank.
- Sits between the game SDRAM mux and the low-level SDRAM command sequencer; benches use it with a behavioural memory.

Parameters:
- AW, 22, per-bank word address width.
- BURST, 2, read burst length in 16-bit words (1..4); a 32-bit slot read uses 2.
- RFSH_PERIOD, 390, clk cycles between refresh requests; 0 disables refresh.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ba0_addr..ba3_addr  in  AW each  word address per bank
- ba_rd  in  4  read/access request per bank, held until ack
- ba_wr  in  1  bank-0 request is a write when high at acceptance
- ba0_din  in  16  write data, bank 0
- ba0_din_m  in  2  write byte mask, bank 0, active high = byte kept
- ba_ack  out  4  one-cycle request-accepted pulse per bank
- ba_dst  out  4  one-cycle pulse with the first read word on data_read
- ba_dok  out  4  high on every cycle data_read carries a valid word for that bank
- ba_rdy  out  4  one-cycle pulse at transaction end (last read word, or write done)
- data_read  out  16  read data shared by all banks
- mem_cs  out  1  memory port request, held until mem_ok
- mem_we  out  1  write qualifier
- mem_addr  out  AW+2  {bank[1:0], word address}
- mem_din  out  16  write data
- mem_mask  out  2  write mask
- mem_dout  in  16  read data
- mem_ok  in  1  one-cycle pulse per word completed
- rfsh  out  1  refresh request, held until rfsh_ok
- rfsh_ok  in  1  refresh done pulse

Behaviour:
- Reset: all outputs 0, FSM in IDLE, word counter 0, refresh timer 0. Reset mid-transaction aborts it; no late strobes after release.
- FSM states: IDLE, ACK, RD, WR, RFSH.
- IDLE:
  - A pending refresh (timer reached RFSH_PERIOD-1) has priority -> RFSH.
  - Otherwise, if any ba_rd bit is set, pick a bank by fixed priority 0>1>2>3 and latch bank, address, ba_wr (bank 0 only; ignored for banks 1-3), din and mask -> ACK.
- ACK (1 cycle): ba_ack[bank]=1. Assert mem_cs next cycle with latched address; mem_we = latched write flag. -> RD or WR.
- RD:
  - Each mem_ok: data_read<=mem_dout registered and ba_dok[bank]=1 the same cycle data_read is valid. mem_addr increments by 1 and mem_cs stays high until BURST words have been received.
  - The first word also pulses ba_dst[bank]. The last word pulses ba_rdy[bank] and drops mem_cs -> IDLE.
  - When BURST=1, dst and rdy occur in the same cycle.
- WR: single word. On mem_ok, pulse ba_rdy[bank], drop mem_cs -> IDLE. No dst/dok for writes.
- Word addresses wrap modulo 2^AW within the bank; the burst never carries into the bank field.
- Minimum read latency: request to ack is 1 cycle; ack to first dok is 1 cycle plus memory latency.
- A request is re-arbitrated only after rdy. A bank holding ba_rd across its own rdy is served again.
- ba_rd deasserted before ack: request dropped silently. Deasserted after ack: the transaction completes anyway.
- Refresh timer counts continuously and saturates while a refresh is pending. rfsh is held in RFSH until rfsh_ok, then the timer clears -> IDLE. A refresh never interrupts a transaction.
- At most one bit of ba_ack/ba_dst/ba_dok/ba_rdy is high at any cycle.

Optional Feature:
- JTCOP_SDRAM_RR_EN defined: round-robin arbitration. Search starts from the bank after the last served one, so banks 1-3 cannot be starved. Refresh still has priority.
- Undefined: fixed priority 0>1>2>3.

Decomposition:
- Shared package jtcop_sdram_pkg holds:
  - FSM state enum.
  - Bank index type (2 bits).
  - Default constants BURST_DEF=2 and RFSH_PERIOD_DEF=390.
- One natural sub-module: jtcop_sdram_arb. Combinational/registered 4-way arbiter with the fixed/round-robin selection; the RR pointer lives inside it.

Test Plan:
- Bank 2 read, ba2_addr=22'h1234, memory returns 16'hAAAA then 16'h5555 with 3-cycle latency -> ack[2] one cycle after request; mem_addr 24'h801234 then 24'h801235; dst[2] with data_read=AAAA; rdy[2] with 5555; dok[2] high exactly 2 cycles.
- Bank 0 write, ba_wr=1, din=16'hBEEF, mask=2'b01 -> mem_we=1, mem_din=BEEF, mem_mask=01, rdy[0] on mem_ok, no dst/dok.
- ba_rd=4'b1010 simultaneous, fixed priority -> bank 1 served first, bank 3 acked after rdy[1]. With JTCOP_SDRAM_RR_EN and bank 1 re-requesting continuously -> banks alternate 1,3,1,3.
- Read at address 22'h3FFFFF, BURST=2 -> second word from 22'h000000 of the same bank.
- RFSH_PERIOD=16 with continuous bank-1 requests -> rfsh asserted between transactions at most one transaction late; timer clears on rfsh_ok.
- rst_n low during RD after first dok -> all outputs 0 immediately; after release no rdy for the aborted read; a new request is served normally.
